// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types and default widths for the memory-access stage.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int REG_W_DEF    = 3;
  localparam int MAX_WAIT_DEF = 64;

  // Access controller states; ERR is terminal until reset.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_e;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_if
// Purpose  : Handshaking data-memory bus. master = pipeline stage,
//            slave = data memory.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_if #(
  parameter int DATA_W = 16
);
  logic              req;
  logic              wr;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              done;

  modport master (output req, wr, addr, wdata, input rdata, done);
  modport slave  (input req, wr, addr, wdata, output rdata, done);
endinterface : dmem_if
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_reg
// Purpose  : MEM/WB pipeline latch. Captures the incoming slot when not
//            stalled, otherwise inserts a bubble (valid/reg_wr cleared,
//            remaining fields held).
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_reg #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_pc_next,
  input  logic              in_jal_en,
  input  logic              in_memToReg,
  input  logic              in_reg_wr,
  input  logic [REG_W-1:0]  in_wr_reg,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_alu_out,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic [DATA_W-1:0] wb_pc_next,
  output logic              wb_jal_en,
  output logic              wb_memToReg,
  output logic              wb_reg_wr,
  output logic [REG_W-1:0]  wb_wr_reg
);

  // Latch update: load the slot, or bubble by killing valid and reg_wr only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_alu_out  <= '0;
      wb_mem_data <= '0;
      wb_pc_next  <= '0;
      wb_jal_en   <= 1'b0;
      wb_memToReg <= 1'b0;
      wb_reg_wr   <= 1'b0;
      wb_wr_reg   <= '0;
    end else if (bubble) begin
      wb_valid  <= 1'b0;
      wb_reg_wr <= 1'b0;
    end else begin
      wb_valid    <= in_valid;
      wb_alu_out  <= in_alu_out;
      wb_mem_data <= in_mem_data;
      wb_pc_next  <= in_pc_next;
      wb_jal_en   <= in_jal_en;
      wb_memToReg <= in_memToReg;
      wb_reg_wr   <= in_reg_wr;
      wb_wr_reg   <= in_wr_reg;
    end
  end

endmodule : mem_wb_reg
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : Pipeline MEM stage. Issues loads/stores on a handshaking data
//            memory bus, stalls upstream while an access is outstanding,
//            traps misaligned accesses, and feeds the MEM/WB latch.
// Options  : MEM_TIMEOUT_EN - abort to ERR after MAX_WAIT wait cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_W    = REG_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [DATA_W-1:0] ex_pc_next,
  input  logic              ex_jal_en,
  input  logic              ex_memToReg,
  input  logic              ex_reg_wr,
  input  logic [REG_W-1:0]  ex_wr_reg,
  dmem_if.master            dmem,
  output logic              mem_busy,
  output logic              wb_valid,
  output logic              wb_jal_en,
  output logic              wb_memToReg,
  output logic              wb_reg_wr,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic [DATA_W-1:0] wb_alu_out,
  output logic [DATA_W-1:0] wb_pc_next,
  output logic [REG_W-1:0]  wb_wr_reg,
  output logic              err
);

  mem_state_e state, state_nxt;
  logic       mem_op;
  logic       req_fsm;
  logic       done_eff;
  logic       timeout;

  assign mem_op = ex_valid & (ex_mem_rd | ex_mem_wr);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Wait counter: zero outside WAIT, so it restarts on every entry to WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = (wait_cnt == CNT_W'(MAX_WAIT - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and request decode; a same-cycle done always beats timeout.
  always_comb begin
    state_nxt = state;
    req_fsm   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (ex_alu_out[0]) begin
            state_nxt = ERR;
          end else begin
            req_fsm = 1'b1;
            if (!dmem.done) state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        req_fsm = 1'b1;
        if (dmem.done)    state_nxt = IDLE;
        else if (timeout) state_nxt = ERR;
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is gated by rst_n so it drops as soon as reset asserts.
  assign dmem.req   = req_fsm & rst_n;
  assign dmem.wr    = dmem.req & ex_mem_wr;
  assign dmem.addr  = ex_alu_out;
  assign dmem.wdata = ex_st_data;

  // A done strobe only counts while our request is on the bus.
  assign done_eff = dmem.done & req_fsm;
  assign mem_busy = (mem_op & ~done_eff) | (state == ERR);
  assign err      = (state == ERR);

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .bubble      (mem_busy),
    .in_valid    (ex_valid),
    .in_alu_out  (ex_alu_out),
    .in_mem_data (ex_mem_rd ? dmem.rdata : '0),
    .in_pc_next  (ex_pc_next),
    .in_jal_en   (ex_jal_en),
    .in_memToReg (ex_memToReg),
    .in_reg_wr   (ex_reg_wr & ex_valid),
    .in_wr_reg   (ex_wr_reg),
    .wb_valid    (wb_valid),
    .wb_alu_out  (wb_alu_out),
    .wb_mem_data (wb_mem_data),
    .wb_pc_next  (wb_pc_next),
    .wb_jal_en   (wb_jal_en),
    .wb_memToReg (wb_memToReg),
    .wb_reg_wr   (wb_reg_wr),
    .wb_wr_reg   (wb_wr_reg)
  );

endmodule : mem_access_stage
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Self-checking bench for mem_access_stage: directed vector table,
//            randomized instruction stream against a transaction-level
//            memory model, and hand-written reset / error / timeout sequences.
// Options  : MEM_TIMEOUT_EN - also exercises the wait-timeout path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_rd, ex_mem_wr, ex_jal_en, ex_memToReg, ex_reg_wr;
  logic [15:0] ex_alu_out, ex_st_data, ex_pc_next;
  logic [2:0]  ex_wr_reg;
  logic        mem_busy, wb_valid, wb_jal_en, wb_memToReg, wb_reg_wr, err;
  logic [15:0] wb_mem_data, wb_alu_out, wb_pc_next;
  logic [2:0]  wb_wr_reg;

  int errors = 0;
  int checks = 0;

  dmem_if #(.DATA_W(16)) dmem ();

  mem_access_stage #(.DATA_W(16), .REG_W(3), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
    .ex_st_data(ex_st_data), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_pc_next(ex_pc_next), .ex_jal_en(ex_jal_en), .ex_memToReg(ex_memToReg),
    .ex_reg_wr(ex_reg_wr), .ex_wr_reg(ex_wr_reg), .dmem(dmem),
    .mem_busy(mem_busy), .wb_valid(wb_valid), .wb_jal_en(wb_jal_en),
    .wb_memToReg(wb_memToReg), .wb_reg_wr(wb_reg_wr), .wb_mem_data(wb_mem_data),
    .wb_alu_out(wb_alu_out), .wb_pc_next(wb_pc_next), .wb_wr_reg(wb_wr_reg),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] alu;
    logic [15:0] st;
    logic        rd;
    logic        wr;
    logic [15:0] pc;
    logic        jal;
    logic        m2r;
    logic        regwr;
    logic [2:0]  wrreg;
    int          lat;
    logic        has_exp;
    logic [15:0] exp_md;
  } vec_t;

  // Reference memory contents; unwritten locations return a fixed pattern.
  logic [15:0] mem_m [logic [15:0]];

  function automatic logic [15:0] mread(input logic [15:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 16'h5A5A;
  endfunction

  function automatic vec_t mk(input logic valid, input logic [15:0] alu, st,
                              input logic rd, wr, input logic [15:0] pc,
                              input logic jal, m2r, regwr, input logic [2:0] wrreg,
                              input int lat, input logic has_exp,
                              input logic [15:0] exp_md);
    vec_t v;
    v.valid = valid; v.alu = alu; v.st = st; v.rd = rd; v.wr = wr; v.pc = pc;
    v.jal = jal; v.m2r = m2r; v.regwr = regwr; v.wrreg = wrreg; v.lat = lat;
    v.has_exp = has_exp; v.exp_md = exp_md;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_jal_en = 1'b0;
    ex_memToReg = 1'b0; ex_reg_wr = 1'b0; ex_alu_out = '0; ex_st_data = '0;
    ex_pc_next = '0; ex_wr_reg = '0;
    dmem.done = 1'b0; dmem.rdata = '0;
  endtask

  // Present one instruction at posedge+1, play the memory for v.lat cycles
  // of latency, then check the MEM/WB latch one edge after completion.
  task automatic run(input vec_t v);
    logic        mop;
    logic [15:0] md_exp;
    int          n;
    mop    = v.valid & (v.rd | v.wr);
    n      = mop ? v.lat : 0;
    md_exp = '0;
    ex_valid = v.valid; ex_alu_out = v.alu; ex_st_data = v.st; ex_mem_rd = v.rd;
    ex_mem_wr = v.wr; ex_pc_next = v.pc; ex_jal_en = v.jal; ex_memToReg = v.m2r;
    ex_reg_wr = v.regwr; ex_wr_reg = v.wrreg;
    for (int k = 0; k <= n; k++) begin
      if (mop) begin
        dmem.done  = (k == n);
        dmem.rdata = mread(v.alu);
      end else begin
        dmem.done  = 1'($urandom_range(0, 1));
        dmem.rdata = 16'($urandom);
      end
      if (k == n) begin
        md_exp = v.rd ? dmem.rdata : 16'h0;
        if (mop && v.wr) mem_m[v.alu] = v.st;
      end
      @(negedge clk);
      chk("dmem_req", dmem.req, mop);
      if (mop) begin
        chk("dmem_addr", dmem.addr, v.alu);
        chk("dmem_wdata", dmem.wdata, v.st);
        chk("dmem_wr", dmem.wr, v.wr);
      end
      chk("mem_busy", mem_busy, mop && (k < n));
      if (k > 0) begin
        chk("bubble_valid", wb_valid, 0);
        chk("bubble_reg_wr", wb_reg_wr, 0);
      end
      @(posedge clk); #1;
    end
    dmem.done = 1'b0;
    chk("wb_valid", wb_valid, v.valid);
    chk("wb_alu_out", wb_alu_out, v.alu);
    chk("wb_pc_next", wb_pc_next, v.pc);
    chk("wb_jal_en", wb_jal_en, v.jal);
    chk("wb_memToReg", wb_memToReg, v.m2r);
    chk("wb_reg_wr", wb_reg_wr, v.regwr & v.valid);
    chk("wb_wr_reg", wb_wr_reg, v.wrreg);
    chk("wb_mem_data", wb_mem_data, v.has_exp ? v.exp_md : md_exp);
    chk("err_clear", err, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t tbl [9];

  initial begin
    tbl[0] = mk(1, 16'h1234, 16'h0000, 0, 0, 16'h0010, 0, 0, 1, 3'd3, 0, 1, 16'h0000);
    tbl[1] = mk(1, 16'h0040, 16'h0000, 1, 0, 16'h0012, 0, 1, 1, 3'd5, 0, 1, 16'hBEEF);
    tbl[2] = mk(1, 16'h0100, 16'h00AA, 0, 1, 16'h0014, 0, 0, 0, 3'd0, 3, 1, 16'h0000);
    tbl[3] = mk(1, 16'h0100, 16'h0000, 1, 0, 16'h0016, 0, 1, 1, 3'd2, 1, 1, 16'h00AA);
    tbl[4] = mk(0, 16'h7777, 16'h0000, 0, 0, 16'h0018, 0, 0, 1, 3'd4, 0, 1, 16'h0000);
    tbl[5] = mk(1, 16'h0050, 16'h0000, 0, 0, 16'h0022, 1, 0, 1, 3'd7, 0, 1, 16'h0000);
    tbl[6] = mk(1, 16'h0040, 16'h0000, 1, 0, 16'h001A, 0, 1, 1, 3'd1, 0, 1, 16'hBEEF);
    tbl[7] = mk(1, 16'h0040, 16'h1111, 0, 1, 16'h001C, 0, 0, 0, 3'd0, 2, 1, 16'h0000);
    tbl[8] = mk(1, 16'h0040, 16'h0000, 1, 0, 16'h001E, 0, 1, 1, 3'd6, 0, 1, 16'h1111);
    mem_m[16'h0040] = 16'hBEEF;

    // Reset state, with a memory op already presented while reset is low.
    rst_n = 1'b0;
    idle();
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_alu_out = 16'h0040;
    #2;
    chk("reset_req", dmem.req, 0);
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_wb_reg_wr", wb_reg_wr, 0);
    chk("reset_wb_alu_out", wb_alu_out, 0);
    chk("reset_wb_mem_data", wb_mem_data, 0);
    chk("reset_err", err, 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, applied back to back.
    for (int i = 0; i < 9; i++) run(tbl[i]);

    // Randomized instruction stream against the memory model.
    for (int i = 0; i < 150; i++) begin
      vec_t v;
      int   kind;
      kind = $urandom_range(0, 2);
      v = mk(($urandom_range(0, 7) != 0), 16'($urandom), 16'($urandom),
             0, 0, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             3'($urandom), $urandom_range(0, 4), 0, 16'h0);
      if (kind != 0) begin
        v.alu = 16'h0200 + 16'(2 * $urandom_range(0, 7));
        v.rd  = (kind == 1);
        v.wr  = (kind == 2);
        v.jal = 1'b0;
      end
      run(v);
    end
    idle();

    // Reset asserted in the second WAIT cycle.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_alu_out = 16'h0300; ex_reg_wr = 1'b1;
    dmem.done = 1'b0;
    @(negedge clk);
    chk("rstwait_req_before", dmem.req, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("rstwait_req_drop", dmem.req, 0);
    chk("rstwait_wb_valid", wb_valid, 0);
    chk("rstwait_wb_reg_wr", wb_reg_wr, 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(mk(1, 16'h0000, 16'h0000, 0, 0, 16'h0022, 1, 0, 1, 3'd7, 0, 1, 16'h0000));

    // Misaligned load: no request, sticky error, permanent stall.
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_alu_out = 16'h0041; ex_reg_wr = 1'b1;
    dmem.done = 1'b0;
    @(negedge clk);
    chk("misalign_req", dmem.req, 0);
    chk("misalign_busy", mem_busy, 1);
    @(posedge clk); #1;
    chk("misalign_err", err, 1);
    idle();
    ex_valid = 1'b1; ex_reg_wr = 1'b1; ex_alu_out = 16'h0002;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("err_busy", mem_busy, 1);
      chk("err_req", dmem.req, 0);
      chk("err_sticky", err, 1);
      @(posedge clk); #1;
      chk("err_wb_valid", wb_valid, 0);
    end
    rst_n = 1'b0;
    #1;
    chk("err_cleared_by_reset", err, 0);
    do_reset();

`ifdef MEM_TIMEOUT_EN
    // Load never completes: ERR after four WAIT cycles.
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_alu_out = 16'h0400;
    dmem.done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("to_err_pending", err, 0);
      chk("to_req_held", dmem.req, 1);
      @(posedge clk); #1;
    end
    chk("to_err_set", err, 1);
    do_reset();
    // Done on the fourth WAIT cycle completes normally.
    run(mk(1, 16'h0402, 16'h0000, 1, 0, 16'h0030, 0, 1, 1, 3'd2, 4, 0, 16'h0));
`else
    // Without the timeout, a long wait simply completes.
    run(mk(1, 16'h0402, 16'h0000, 1, 0, 16'h0030, 0, 1, 1, 3'd2, 10, 0, 16'h0));
`endif
    chk("final_err", err, 0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_access_stage
`default_nettype wire
